// File: rtl/rgbseq_pkg.sv
// Shared definitions for the RGB LED sequencer: register map, CTRL bits, FSM encoding
// and step-word field helpers.
package rgbseq_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATIC = 3'd1;
    localparam logic [2:0] ADDR_STEP0  = 3'd4;

    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_LOOP  = 1;
    localparam int unsigned CTRL_TEST  = 2;
    localparam int unsigned CTRL_START = 3;

    localparam int unsigned DUR_LSB = 24;
    localparam int unsigned R_LSB   = 16;
    localparam int unsigned G_LSB   = 8;
    localparam int unsigned B_LSB   = 0;

    typedef enum logic {StIdle, StRun} seq_state_e;

    function automatic logic [7:0] step_dur(input logic [31:0] step);
        return step[DUR_LSB +: 8];
    endfunction

    function automatic logic [23:0] step_rgb(input logic [31:0] step);
        return step[23:0];
    endfunction

endpackage

// File: rtl/rgb_pwm.sv
// Three-channel 8-bit PWM; duty is latched only at the end of a period so every
// period is generated with a single, consistent duty value.
module rgb_pwm (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] rgb_i,
    output logic [2:0]  pwm_o
);

    logic [7:0]  cnt_q, cnt_d;
    logic [23:0] duty_q, duty_d;
    logic [2:0]  pwm_q, pwm_d;

    always_comb begin
        cnt_d  = cnt_q + 8'd1;
        duty_d = (cnt_q == 8'hFF) ? rgb_i : duty_q;
        pwm_d  = {cnt_q < duty_q[23:16], cnt_q < duty_q[15:8], cnt_q < duty_q[7:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            duty_q <= '0;
            pwm_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_led_sequencer.sv
// Register-programmable RGB LED controller: static colour or a 4-step timed colour
// sequence, rendered as 1-bit PWM streams for the LED wrapper.
module rgb_led_sequencer import rgbseq_pkg::*; #(
    parameter int unsigned TICK_DIV = 12000,
    parameter int unsigned N_STEPS  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic        test_mode,
    output logic        out_r,
    output logic        out_g,
    output logic        out_b,
    output logic        busy,
    output logic [1:0]  step_idx,
    output logic        seq_done
);

    localparam logic [1:0]  LAST_STEP = 2'(N_STEPS - 1);
    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    seq_state_e  state_q, state_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [23:0] static_q, static_d;
    logic [31:0] step_q [N_STEPS];
    logic [31:0] step_d [N_STEPS];
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  dur_q, dur_d;
    logic [23:0] cur_q, cur_d;
    logic [15:0] presc_q, presc_d;
    logic        done_q, done_d;

    logic        tick, ctrl_wr, en_now, start;
    logic [1:0]  next_idx;
    logic [23:0] active_rgb;
    logic [2:0]  pwm;

    assign tick     = (presc_q == TICK_LAST);
    assign ctrl_wr  = wr_en && (wr_addr == ADDR_CTRL);
    // A CTRL write takes effect on the FSM in the same cycle it is presented.
    assign en_now   = ctrl_wr ? wr_data[CTRL_EN] : ctrl_q[CTRL_EN];
    assign start    = ctrl_wr && wr_data[CTRL_START] && wr_data[CTRL_EN];
    assign next_idx = idx_q + 2'd1;

    always_comb begin
        ctrl_d   = ctrl_q;
        static_d = static_q;
        step_d   = step_q;
        state_d  = state_q;
        idx_d    = idx_q;
        dur_d    = dur_q;
        cur_d    = cur_q;
        done_d   = 1'b0;
        presc_d  = tick ? 16'd0 : presc_q + 16'd1;

        if (wr_en) begin
            if (wr_addr == ADDR_CTRL) begin
                ctrl_d = wr_data[2:0];
            end else if (wr_addr == ADDR_STATIC) begin
                static_d = wr_data[23:0];
            end else if (wr_addr[2]) begin
                step_d[wr_addr[1:0]] = wr_data;
            end
        end

        if (!en_now) begin
            state_d = StIdle;
        end else if (start) begin
            presc_d = '0;
            if (step_dur(step_q[0]) == 8'd0) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end else begin
                state_d = StRun;
                idx_d   = '0;
                dur_d   = step_dur(step_q[0]);
                cur_d   = step_rgb(step_q[0]);
            end
        end else if (state_q == StRun && tick) begin
            if (dur_q > 8'd1) begin
                dur_d = dur_q - 8'd1;
            end else if (idx_q != LAST_STEP && step_dur(step_q[next_idx]) != 8'd0) begin
                idx_d = next_idx;
                dur_d = step_dur(step_q[next_idx]);
                cur_d = step_rgb(step_q[next_idx]);
            end else if (ctrl_q[CTRL_LOOP] && step_dur(step_q[0]) != 8'd0) begin
                idx_d = '0;
                dur_d = step_dur(step_q[0]);
                cur_d = step_rgb(step_q[0]);
            end else begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ctrl_q   <= '0;
            static_q <= '0;
            step_q   <= '{default: '0};
            idx_q    <= '0;
            dur_q    <= '0;
            cur_q    <= '0;
            presc_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            static_q <= static_d;
            step_q   <= step_d;
            idx_q    <= idx_d;
            dur_q    <= dur_d;
            cur_q    <= cur_d;
            presc_q  <= presc_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        if (state_q == StRun) begin
            active_rgb = cur_q;
        end else if (ctrl_q[CTRL_EN]) begin
            active_rgb = static_q;
        end else begin
            active_rgb = '0;
        end
    end

    rgb_pwm u_pwm (
        .clk   (clk),
        .rst   (rst),
        .rgb_i (active_rgb),
        .pwm_o (pwm)
    );

    assign out_r     = pwm[2];
    assign out_g     = pwm[1];
    assign out_b     = pwm[0];
    assign test_mode = ctrl_q[CTRL_TEST];
    assign busy      = (state_q == StRun);
    assign step_idx  = busy ? idx_q : 2'd0;
    assign seq_done  = done_q;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Directed bench for rgb_led_sequencer with TICK_DIV=4: register-write vectors, PWM duty
// vectors, and hand-written sequence, loop, restart and reset scenarios.
module tb_rgb_led_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        test_mode, out_r, out_g, out_b, busy, seq_done;
    logic [1:0]  step_idx;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
        logic        exp_tm;
        logic        exp_busy;
        logic        exp_done;
    } wr_vec_t;

    typedef struct {
        logic [23:0] rgb;
        int          exp_r;
        int          exp_g;
        int          exp_b;
    } pwm_vec_t;

    wr_vec_t  wv [4];
    pwm_vec_t pv [2];

    rgb_led_sequencer #(
        .TICK_DIV (4),
        .N_STEPS  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .test_mode (test_mode),
        .out_r     (out_r),
        .out_g     (out_g),
        .out_b     (out_b),
        .busy      (busy),
        .step_idx  (step_idx),
        .seq_done  (seq_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
    endtask

    task automatic count_pwm(output int r, output int g, output int b);
        r = 0;
        g = 0;
        b = 0;
        repeat (256) begin
            step();
            r += int'(out_r);
            g += int'(out_g);
            b += int'(out_b);
        end
    endtask

    initial begin
        int r, g, b, any;

        wv[0] = '{3'd0, 32'h0000_0004, 1'b1, 1'b0, 1'b0};
        wv[1] = '{3'd2, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        wv[2] = '{3'd0, 32'h0000_000C, 1'b1, 1'b0, 1'b0};
        wv[3] = '{3'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        pv[0] = '{24'h01_FE_00, 1, 254, 0};
        pv[1] = '{24'h80_00_FF, 128, 0, 255};

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_test_mode", test_mode, 0);
        chk("rst_seq_done", seq_done, 0);
        chk("rst_step_idx", step_idx, 0);
        chk("rst_rgb", {out_r, out_g, out_b}, 0);

        any = 0;
        repeat (600) begin
            step();
            any += int'(out_r | out_g | out_b | busy | seq_done | test_mode);
        end
        chk("idle_quiet", any, 0);

        for (int i = 0; i < 4; i++) begin
            wr(wv[i].addr, wv[i].data);
            chk($sformatf("wr%0d_test_mode", i), test_mode, wv[i].exp_tm);
            chk($sformatf("wr%0d_busy", i), busy, wv[i].exp_busy);
            chk($sformatf("wr%0d_seq_done", i), seq_done, wv[i].exp_done);
        end
        count_pwm(r, g, b);
        chk("disabled_rgb_sum", r + g + b, 0);

        wr(3'd0, 32'h1);
        for (int i = 0; i < 2; i++) begin
            wr(3'd1, {8'h00, pv[i].rgb});
            repeat (600) step();
            count_pwm(r, g, b);
            chk($sformatf("pwm%0d_r", i), r, pv[i].exp_r);
            chk($sformatf("pwm%0d_g", i), g, pv[i].exp_g);
            chk($sformatf("pwm%0d_b", i), b, pv[i].exp_b);
        end

        // One-shot sequence: 2 ticks of step 0, 3 ticks of step 1, then end.
        wr(3'd4, 32'h02FF_0000);
        wr(3'd5, 32'h0300_FF00);
        wr(3'd6, 32'h0000_0000);
        wr(3'd0, 32'h9);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("seq_idx_k%0d", k), step_idx, (k < 8) ? 0 : 1);
            chk($sformatf("seq_busy_k%0d", k), busy, 1);
            chk($sformatf("seq_done_k%0d", k), seq_done, 0);
            step();
        end
        chk("seq_end_busy", busy, 0);
        chk("seq_end_done", seq_done, 1);
        chk("seq_end_idx", step_idx, 0);
        step();
        chk("seq_done_one_cycle", seq_done, 0);
        repeat (600) step();
        count_pwm(r, g, b);
        chk("revert_static", {r[15:0], g[15:0], b[15:0]}, {16'd128, 16'd0, 16'd255});

        wr(3'd0, 32'hB);
        for (int k = 0; k < 100; k++) begin
            chk($sformatf("loop_idx_k%0d", k), step_idx, ((k % 20) < 8) ? 0 : 1);
            chk($sformatf("loop_busy_k%0d", k), busy, 1);
            chk($sformatf("loop_done_k%0d", k), seq_done, 0);
            step();
        end
        wr(3'd0, 32'h2);
        chk("disable_busy", busy, 0);
        chk("disable_done", seq_done, 0);
        chk("disable_idx", step_idx, 0);
        step();
        chk("disable_done_late", seq_done, 0);
        repeat (300) step();
        count_pwm(r, g, b);
        chk("disable_rgb_sum", r + g + b, 0);

        wr(3'd4, 32'h0);
        wr(3'd0, 32'h9);
        chk("zero_step0_busy", busy, 0);
        chk("zero_step0_done", seq_done, 1);
        any = 0;
        repeat (20) begin
            step();
            any += int'(busy) + int'(seq_done);
        end
        chk("zero_step0_quiet", any, 0);

        // Restart lands on the edge where the prescaler tick also fires.
        wr(3'd4, 32'h02FF_0000);
        wr(3'd0, 32'h9);
        repeat (11) step();
        chk("pre_restart_idx", step_idx, 1);
        wr(3'd0, 32'hD);
        chk("restart_test_mode", test_mode, 1);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("restart_idx_k%0d", k), step_idx, (k < 8) ? 0 : 1);
            chk($sformatf("restart_busy_k%0d", k), busy, 1);
            if (k < 8) step();
        end

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_idx", step_idx, 0);
        chk("midrst_test_mode", test_mode, 0);
        chk("midrst_done", seq_done, 0);
        chk("midrst_rgb", {out_r, out_g, out_b}, 0);
        wr(3'd0, 32'h9);
        chk("postrst_step0_cleared", {busy, seq_done}, 2'b01);
        repeat (600) step();
        count_pwm(r, g, b);
        chk("postrst_static_cleared", r + g + b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb_led_sequencer.md
Name: rgb_led_sequencer

Overview:
- Register-programmable controller that drives the RGB LED wrapper's `test_mode` and `in_r`/`in_g`/`in_b` inputs.
- Holds a static colour plus a 4-step colour/duration sequence, and steps through it on a prescaled tick.
- Converts the active 8-bit-per-channel colour into 1-bit PWM streams.
- Sits between the SPI register decoder (write port) and the LED wrapper, in the same clock domain, after the PLL.

Parameters:
- TICK_DIV, 12000, clk cycles per sequencer tick (1 ms at 12 MHz); legal range 2..65535.
- N_STEPS, 4, sequence table depth; fixed at 4 for this revision (2-bit step index).

Ports:
- clk  input  1  system clock (PLL output)
- rst  input  1  reset, synchronous, active-high
- wr_en  input  1  register write strobe, one cycle
- wr_addr  input  3  register address
- wr_data  input  32  register write data
- test_mode  output  1  drives wrapper test_mode
- out_r  output  1  PWM red, drives wrapper in_r
- out_g  output  1  PWM green, drives wrapper in_g
- out_b  output  1  PWM blue, drives wrapper in_b
- busy  output  1  high while state is RUN
- step_idx  output  2  current sequence step (0 when not RUN)
- seq_done  output  1  one-cycle pulse when a non-looping sequence ends

Behaviour:
- Register map:
  - addr 0 CTRL: bit0 enable, bit1 loop, bit2 test_mode, bit3 start (write-1 strobe, not stored).
  - addr 1 STATIC: [23:16] R, [15:8] G, [7:0] B.
  - addr 4..7 STEP0..3: [31:24] duration in ticks, [23:0] RGB as STATIC.
  - addr 2..3: writes ignored.
- Reset: CTRL=0, STATIC=0, all steps=0, state IDLE, prescaler=0, PWM counter=0. All outputs 0.
- test_mode output = registered CTRL.bit2. It updates 1 cycle after the write. It is independent of enable and of state.
- Prescaler: counts 0..TICK_DIV-1 and emits a tick when it wraps. It clears to 0 on an accepted start, so the first tick comes TICK_DIV cycles after start.
- FSM states: IDLE, RUN.
  - IDLE→RUN: wr_en at addr 0 with bit3=1 and bit0=1 in the same write, and STEP0 duration ≠ 0. Loads step 0 and dur_cnt = STEP0 duration.
  - If STEP0 duration = 0: stay IDLE and pulse seq_done.
  - RUN, on tick: if dur_cnt > 1, decrement. If dur_cnt = 1, advance to the next step.
  - Advancing from step i: the next step is i+1. If i = 3, or the next step's duration = 0, the sequence has ended:
    - loop=1: reload step 0 (STEP0 duration = 0 → IDLE with seq_done).
    - loop=0: IDLE, seq_done pulses 1 cycle.
  - RUN + start strobe (with enable=1): restart at step 0, prescaler cleared.
  - Any cycle with enable=0 (after a CTRL write): IDLE immediately, no seq_done.
- Step colour/duration are sampled when the step is loaded. Table writes during RUN affect only later loads.
- Active colour:
  - RUN: the colour of the loaded step.
  - IDLE with enable=1: STATIC.
  - enable=0: 0.
- PWM:
  - Free-running 8-bit counter pwm_cnt.
  - out_x registered = (pwm_cnt < duty_x). Duty 0 is never on; duty 255 is on 255 of 256 cycles.
  - The duty register updates only when pwm_cnt = 255, so there are no glitched periods. A colour change is visible from the next PWM period start.
- Latency: the start write at cycle N gives busy=1 at N+1.
- Simultaneous events: a tick and a start in the same cycle → start wins. A CTRL write with enable=0 and start=1 → disable wins.

Decomposition:
- Package rgbseq_pkg:
  - Register address localparams (ADDR_CTRL, ADDR_STATIC, ADDR_STEP0).
  - CTRL bit positions.
  - FSM state encoding.
  - Colour field offsets.
- Sub-module rgb_pwm: 8-bit counter, period-aligned duty latch, 3 comparators. It is instantiated once.

Test Plan (bench uses TICK_DIV=4):
- Reset, then idle 600 cycles → all outputs 0, busy=0; write CTRL=0x4 → test_mode=1 one cycle later, out_* stay 0.
- STATIC=0x80_00_FF, CTRL=0x1 → over a full 256-cycle aligned period, out_r high exactly 128 cycles, out_g 0, out_b 255.
- STEP0=0x02_FF0000, STEP1=0x03_00FF00, STEP2=0, CTRL=0x9 → busy at N+1; step_idx=0 for 8 cycles, then 1 for 12 cycles; then IDLE with one seq_done pulse; colour then reverts to STATIC.
- Same table, CTRL=0xB (loop) → step_idx sequence 0,1,0,1… for 100 cycles, never seq_done; write CTRL=0x2 → busy=0 next cycle, outputs 0, no seq_done.
- STEP0=0, CTRL=0x9 → remains IDLE, seq_done single pulse, busy never 1.
- Mid-run (step 1), rewrite CTRL=0x9 on the same cycle a tick fires → step_idx=0, full STEP0 duration counted from restart; assert rst mid-run → all registers/outputs 0 next cycle.
